fft_stage_scheduler: RTL and testbench

FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

---
 rtl/fft_stage_scheduler_if.sv | 51 +++++
 rtl/fft_stage_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_fft_stage_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_scheduler_if.sv
// ----------------------------------------------------------------------------
// fft_stage_scheduler_if
//
// Bundles the start/issue/write-back signals of the radix-2 FFT stage
// scheduler. Signal names keep their original i_/o_ prefixes, seen from the
// scheduler's point of view.
//
// Modports:
//   master : the scheduler (drives butterfly issue and status, receives start,
//            ready and write-back pulses)
//   slave  : the environment (sample loader, butterfly unit, RAM write-back)
//
// Signals:
//   i_DATA_LOADED     1   start pulse, sample RAM filled
//   i_SAMPLES_NUMBER  12  transform length N
//   i_BFLY_READY      1   butterfly unit accepts the current issue
//   i_WB_DONE         1   one issued butterfly has been written back
//   o_BFLY_VALID      1   butterfly issue request
//   o_ADDR_A/o_ADDR_B 12  operand RAM indices
//   o_TW_IDX          11  twiddle ROM index
//   o_STAGE           4   current stage number
//   o_BUSY            1   RUN or DRAIN
//   o_CALC_END        1   transform finished (level)
//   o_ERR             1   last start carried an invalid N
// ----------------------------------------------------------------------------
interface fft_stage_scheduler_if;
    logic        i_DATA_LOADED;
    logic [11:0] i_SAMPLES_NUMBER;
    logic        i_BFLY_READY;
    logic        i_WB_DONE;
    logic        o_BFLY_VALID;
    logic [11:0] o_ADDR_A;
    logic [11:0] o_ADDR_B;
    logic [10:0] o_TW_IDX;
    logic [3:0]  o_STAGE;
    logic        o_BUSY;
    logic        o_CALC_END;
    logic        o_ERR;

    modport master (
        input  i_DATA_LOADED, i_SAMPLES_NUMBER, i_BFLY_READY, i_WB_DONE,
        output o_BFLY_VALID, o_ADDR_A, o_ADDR_B, o_TW_IDX, o_STAGE,
               o_BUSY, o_CALC_END, o_ERR
    );

    modport slave (
        output i_DATA_LOADED, i_SAMPLES_NUMBER, i_BFLY_READY, i_WB_DONE,
        input  o_BFLY_VALID, o_ADDR_A, o_ADDR_B, o_TW_IDX, o_STAGE,
               o_BUSY, o_CALC_END, o_ERR
    );
endinterface

// File: rtl/fft_stage_scheduler.sv
// ----------------------------------------------------------------------------
// fft_stage_scheduler
//
// Sequences the butterflies of an in-place radix-2 DIT FFT of length N
// (power of two, 2..2048). For each stage s (half = 2^s) it walks groups of
// 2*half samples starting at base and issues, for j = 0..half-1:
//   A = base+j, B = base+j+half, twiddle = j*(N >> (s+1)).
// At most MAX_OUT butterflies may be in flight (issued, not yet written
// back). At the end of each stage the scheduler drains all write-backs before
// starting the next stage, so no stage reads a sample still being written.
//
// Parameters:
//   MAX_OUT  maximum outstanding butterflies (1..15)
//
// Ports:
//   i_clk    clock, rising edge
//   i_rstn   asynchronous active-low reset
//   bus      fft_stage_scheduler_if.master (start, issue, write-back, status)
// ----------------------------------------------------------------------------
module fft_stage_scheduler #(
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    fft_stage_scheduler_if.master       bus
);

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] n_q, n_d;          // latched transform length
    logic [3:0]  l_q, l_d;          // log2(N) = number of stages
    logic [3:0]  s_q, s_d;          // current stage
    logic [10:0] j_q, j_d;          // butterfly index inside the group
    logic [11:0] base_q, base_d;    // first sample of the current group
    logic [3:0]  out_q, out_d;      // outstanding butterflies
    logic        err_q, err_d;

    logic [11:0] half;
    logic [11:0] half_m1;
    logic [11:0] span;
    logic        n_valid;
    logic [3:0]  n_log2;
    logic        run_st;
    logic        issue_ok;
    logic        hs;
    logic        wb_eff;
    logic        j_wrap;
    logic        last_bfly;
    logic        start_acc;
    logic [3:0]  tw_shift;

    // ------------------------------------------------------------------
    // Length decode: valid N has exactly one bit set and is at least 2.
    // ------------------------------------------------------------------
    always_comb begin
        n_log2 = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (bus.i_SAMPLES_NUMBER[i]) begin
                n_log2 = 4'(i);
            end
        end
    end

    assign n_valid = (bus.i_SAMPLES_NUMBER >= 12'd2) &&
                     ((bus.i_SAMPLES_NUMBER & (bus.i_SAMPLES_NUMBER - 12'd1)) == '0);

    // ------------------------------------------------------------------
    // Stage geometry and handshake
    // ------------------------------------------------------------------
    assign half      = 12'd1 << s_q;
    assign half_m1   = half - 12'd1;
    assign span      = half << 1;
    assign run_st    = (state_q == RUN);
    assign issue_ok  = run_st && (out_q != MAX_OUT_C);
    assign hs        = issue_ok && bus.i_BFLY_READY;
    // A write-back with nothing outstanding is a stray pulse; drop it.
    assign wb_eff    = bus.i_WB_DONE && (out_q != '0);
    assign j_wrap    = ({1'b0, j_q} == half_m1);
    assign last_bfly = j_wrap && ((base_q + span) == n_q);
    assign start_acc = ((state_q == IDLE) || (state_q == DONE)) && bus.i_DATA_LOADED;
    // N >> (s+1) is 2^(L-s-1), so the twiddle multiply reduces to a shift.
    assign tw_shift  = l_q - s_q - 4'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        l_d     = l_q;
        s_d     = s_q;
        j_d     = j_q;
        base_d  = base_q;
        out_d   = out_q;
        err_d   = err_q;

        if (hs && !wb_eff) begin
            out_d = out_q + 4'd1;
        end else if (!hs && wb_eff) begin
            out_d = out_q - 4'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    n_d    = bus.i_SAMPLES_NUMBER;
                    l_d    = n_log2;
                    s_d    = '0;
                    j_d    = '0;
                    base_d = '0;
                    out_d  = '0;
                    if (n_valid) begin
                        state_d = RUN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end

            RUN: begin
                if (hs) begin
                    if (j_wrap) begin
                        j_d    = '0;
                        base_d = base_q + span;
                    end else begin
                        j_d = j_q + 11'd1;
                    end
                    if (last_bfly) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Looking at out_d rather than out_q lets the final write-back
                // release the next stage on the same edge, so its first issue
                // appears the cycle right after that pulse.
                if (out_d == '0) begin
                    if (s_q < (l_q - 4'd1)) begin
                        state_d = RUN;
                        s_d     = s_q + 4'd1;
                        j_d     = '0;
                        base_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            n_q     <= '0;
            l_q     <= '0;
            s_q     <= '0;
            j_q     <= '0;
            base_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            l_q     <= l_d;
            s_q     <= s_d;
            j_q     <= j_d;
            base_q  <= base_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: operand/twiddle indices are only meaningful in RUN and are
    // held at zero elsewhere.
    // ------------------------------------------------------------------
    assign bus.o_BFLY_VALID = issue_ok;
    assign bus.o_ADDR_A     = run_st ? (base_q + {1'b0, j_q}) : '0;
    assign bus.o_ADDR_B     = run_st ? (base_q + {1'b0, j_q} + half) : '0;
    assign bus.o_TW_IDX     = run_st ? (j_q << tw_shift) : '0;
    assign bus.o_STAGE      = s_q;
    assign bus.o_BUSY       = (state_q == RUN) || (state_q == DRAIN);
    assign bus.o_CALC_END   = (state_q == DONE);
    assign bus.o_ERR        = err_q;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fft_stage_scheduler
//
// Directed bench for fft_stage_scheduler. Every accepted butterfly issue is
// logged as {stage, A, B, tw} and compared against hand-computed tables.
// Write-backs come from a small model: none, a fixed 2-cycle delay, or a
// flush that returns one write-back per cycle while any are owed.
// ----------------------------------------------------------------------------
module tb_fft_stage_scheduler;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    fft_stage_scheduler_if bus ();

    fft_stage_scheduler #(
        .MAX_OUT(8)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int          tests  = 0;
    int          failed = 0;
    logic [38:0] issues[$];
    int          mode;          // 0: manual, 1: 2-cycle delay, 2: flush
    bit          toggle_ready;
    logic [7:0]  wb_pipe;
    int          pending;

    int e8a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int e8b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int e8t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    function automatic logic [38:0] pk(input int s, input int a, input int b, input int tw);
        logic [31:0] sv, av, bv, tv;
        sv = s; av = a; bv = b; tv = tw;
        return {sv[3:0], av[11:0], bv[11:0], tv[10:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_issue(input string tag, input int idx,
                               input int s, input int a, input int b, input int tw);
        logic [38:0] obs;
        obs = (idx < issues.size()) ? issues[idx] : '1;
        check(tag, {25'd0, obs}, {25'd0, pk(s, a, b, tw)});
    endtask

    task automatic tick();
        logic hs, wb_now;
        hs     = bus.o_BFLY_VALID & bus.i_BFLY_READY;
        wb_now = bus.i_WB_DONE;
        if (hs) issues.push_back({bus.o_STAGE, bus.o_ADDR_A, bus.o_ADDR_B, bus.o_TW_IDX});
        @(posedge clk);
        #1;
        wb_pipe = {wb_pipe[6:0], hs};
        if (wb_now && pending > 0) pending--;
        if (hs) pending++;
        case (mode)
            1:       bus.i_WB_DONE = wb_pipe[1];
            2:       bus.i_WB_DONE = (pending > 0);
            default: bus.i_WB_DONE = 1'b0;
        endcase
        if (toggle_ready) bus.i_BFLY_READY = ~bus.i_BFLY_READY;
    endtask

    task automatic start(input int n);
        bus.i_SAMPLES_NUMBER = 12'(n);
        bus.i_DATA_LOADED    = 1'b1;
        tick();
        bus.i_DATA_LOADED    = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int k;
        k = 0;
        while (bus.o_CALC_END !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check(tag, {63'd0, bus.o_CALC_END}, 64'd1);
    endtask

    function automatic logic [42:0] all_outs();
        return {bus.o_BFLY_VALID, bus.o_BUSY, bus.o_CALC_END, bus.o_ERR, bus.o_STAGE,
                bus.o_ADDR_A, bus.o_ADDR_B, bus.o_TW_IDX};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int k;

        rstn                 = 1'b0;
        bus.i_DATA_LOADED    = 1'b0;
        bus.i_SAMPLES_NUMBER = '0;
        bus.i_BFLY_READY     = 1'b0;
        bus.i_WB_DONE        = 1'b0;
        mode                 = 0;
        toggle_ready         = 1'b0;
        wb_pipe              = '0;
        pending              = 0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {21'd0, all_outs()}, 64'd0);
        rstn = 1'b1;
        tick();
        check("idle_outs", {21'd0, all_outs()}, 64'd0);

        // ---------------- N=8, ready=1, write-back 2 cycles after issue ----------------
        bus.i_BFLY_READY = 1'b1;
        mode = 1;
        issues.delete();
        start(8);
        check("n8_running", {61'd0, bus.o_BUSY, bus.o_CALC_END, bus.o_ERR}, 64'b100);
        run_until_done("n8_done", 200);
        for (int i = 0; i < 12; i++) begin
            check_issue($sformatf("n8_issue%0d", i), i, i / 4, e8a[i], e8b[i], e8t[i]);
        end
        check("n8_count", issues.size(), 12);
        repeat (3) tick();
        check("n8_done_hold", {61'd0, bus.o_BUSY, bus.o_CALC_END, bus.o_ERR}, 64'b010);
        check("n8_done_novalid", {63'd0, bus.o_BFLY_VALID}, 64'd0);

        // ---------------- invalid N=6, then N=4 ----------------
        mode = 0;
        issues.delete();
        start(6);
        check("n6_flags", {60'd0, bus.o_BFLY_VALID, bus.o_BUSY, bus.o_CALC_END, bus.o_ERR}, 64'b0011);
        repeat (3) tick();
        check("n6_no_issue", issues.size(), 0);
        check("n6_err_hold", {62'd0, bus.o_CALC_END, bus.o_ERR}, 64'b11);
        mode = 2;
        start(4);
        check("n4_err_clear", {61'd0, bus.o_BUSY, bus.o_CALC_END, bus.o_ERR}, 64'b100);
        run_until_done("n4_done", 100);
        check_issue("n4_issue0", 0, 0, 0, 1, 0);
        check_issue("n4_issue1", 1, 0, 2, 3, 0);
        check_issue("n4_issue2", 2, 1, 0, 2, 0);
        check_issue("n4_issue3", 3, 1, 1, 3, 1);
        check("n4_count", issues.size(), 4);

        // ---------------- N=16, ready toggling, write-back withheld ----------------
        mode = 0;
        toggle_ready = 1'b1;
        issues.delete();
        start(16);
        repeat (30) tick();
        check("n16_stall_count", issues.size(), 8);
        check("n16_stall_flags", {62'd0, bus.o_BFLY_VALID, bus.o_BUSY}, 64'b01);
        check_issue("n16_issue7", 7, 0, 14, 15, 0);
        mode = 2;
        run_until_done("n16_done", 400);
        toggle_ready = 1'b0;
        bus.i_BFLY_READY = 1'b1;
        check_issue("n16_issue8", 8, 1, 0, 2, 0);
        check_issue("n16_issue9", 9, 1, 1, 3, 4);
        check_issue("n16_issue24", 24, 3, 0, 8, 0);
        check_issue("n16_issue31", 31, 3, 7, 15, 7);
        check("n16_count", issues.size(), 32);

        // ---------------- stage boundary with a write-back delayed 20 cycles ----------------
        mode = 0;
        issues.delete();
        start(4);
        tick();
        tick();
        check("drain_enter", {61'd0, bus.o_BFLY_VALID, bus.o_BUSY, bus.o_STAGE == 4'd0}, 64'b011);
        bus.i_WB_DONE = 1'b1;
        tick();
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.o_BUSY !== 1'b1 || bus.o_BFLY_VALID !== 1'b0) bad++;
        end
        check("drain_hold", bad, 0);
        bus.i_WB_DONE = 1'b1;
        tick();
        check("drain_release_valid", {63'd0, bus.o_BFLY_VALID}, 64'd1);
        check("drain_release_addr", {25'd0, bus.o_STAGE, bus.o_ADDR_A, bus.o_ADDR_B, bus.o_TW_IDX},
              {25'd0, pk(1, 0, 2, 0)});
        mode = 2;
        run_until_done("drain_done", 100);
        check("drain_count", issues.size(), 4);

        // ---------------- N=32: MAX_OUT stall, ignored start, reset mid-stage 1 ----------------
        mode = 0;
        issues.delete();
        start(32);
        repeat (12) tick();
        check("n32_stall_count", issues.size(), 8);
        check("n32_stall_valid", {62'd0, bus.o_BFLY_VALID, bus.o_BUSY}, 64'b01);
        check("n32_stall_addr", {25'd0, bus.o_STAGE, bus.o_ADDR_A, bus.o_ADDR_B, bus.o_TW_IDX},
              {25'd0, pk(0, 16, 17, 0)});
        repeat (3) tick();
        check("n32_stall_stable", {25'd0, bus.o_STAGE, bus.o_ADDR_A, bus.o_ADDR_B, bus.o_TW_IDX},
              {25'd0, pk(0, 16, 17, 0)});
        mode = 2;
        repeat (3) tick();
        bus.i_SAMPLES_NUMBER = 12'd4;
        bus.i_DATA_LOADED    = 1'b1;
        tick();
        bus.i_DATA_LOADED    = 1'b0;
        check("n32_dl_ignored", {61'd0, bus.o_BUSY, bus.o_CALC_END, bus.o_ERR}, 64'b100);
        k = 0;
        while (issues.size() < 18 && k < 200) begin
            tick();
            k++;
        end
        check("n32_progress", {63'd0, issues.size() >= 18}, 64'd1);
        check_issue("n32_issue8", 8, 0, 16, 17, 0);
        check_issue("n32_issue15", 15, 0, 30, 31, 0);
        check_issue("n32_issue16", 16, 1, 0, 2, 0);
        check_issue("n32_issue17", 17, 1, 1, 3, 8);

        rstn = 1'b0;
        #1;
        check("reset_mid_outs", {21'd0, all_outs()}, 64'd0);
        @(posedge clk);
        #1;
        rstn              = 1'b1;
        mode              = 0;
        pending           = 0;
        wb_pipe           = '0;
        bus.i_WB_DONE     = 1'b1;
        tick();
        repeat (2) tick();
        check("post_reset_idle", {21'd0, all_outs()}, 64'd0);

        issues.delete();
        start(32);
        check("restart_valid", {63'd0, bus.o_BFLY_VALID}, 64'd1);
        check("restart_addr", {25'd0, bus.o_STAGE, bus.o_ADDR_A, bus.o_ADDR_B, bus.o_TW_IDX},
              {25'd0, pk(0, 0, 1, 0)});
        repeat (12) tick();
        check("restart_out_limit", issues.size(), 8);
        check_issue("restart_issue1", 1, 0, 2, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
